// File: rtl/core_ldst_sized.sv
// rtl/core_ldst_sized.sv - sized load/store unit: byte enables, lane replication, load extension
// One access in flight; misaligned accesses fault without a bus request.
module core_ldst_sized #(
  parameter int REG_W  = 4,
  parameter int ADDR_W = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  load,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [REG_W-1:0]      rd,
  input  logic [31:0]           a,
  input  logic [31:0]           b,
  input  logic                  data_ready,
  input  logic [31:0]           data_data_rd,
  input  logic                  wb_stall,
  output logic                  data_start,
  output logic                  data_write,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [3:0]            data_data_be,
  output logic [31:0]           data_data_wr,
  output logic                  wb_ready,
  output logic [REG_W-1:0]      wb_rd,
  output logic [31:0]           wb_value,
  output logic [(1<<REG_W)-1:0] raw_mask,
  output logic                  ldst_wait,
  output logic                  fault,
  output logic [31:0]           fault_addr
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] addr;
  logic [1:0]  lane;
  logic        aligned;
  logic        accept;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        lat_load;
  logic        lat_sign;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic [31:0] sh;
  logic [31:0] ext;

  always_comb begin
    addr    = load ? a : b;
    lane    = addr[1:0];
    aligned = 1'b0;
    be      = 4'b1111;
    wdata   = a;
    case (size)
      2'd0: begin
        aligned = 1'b1;
        be      = 4'b0001 << lane;
        wdata   = {4{a[7:0]}};
      end
      2'd1: begin
        aligned = ~lane[0];
        be      = 4'b0011 << lane;
        wdata   = {2{a[15:0]}};
      end
      2'd2: aligned = (lane == 2'd0);
      default: aligned = 1'b0;
    endcase
    // Starts while busy or while writeback is stalled are dropped.
    accept = (state == IDLE) && start && !wb_stall;
  end

  always_comb begin
    sh  = data_data_rd >> {lat_lane, 3'b000};
    ext = sh;
    case (lat_size)
      2'd0:    ext = {{24{lat_sign & sh[7]}}, sh[7:0]};
      2'd1:    ext = {{16{lat_sign & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    raw_mask  = '0;
    ldst_wait = (state != IDLE) || wb_stall;
    case (state)
      IDLE: if (accept && aligned) state_nx = WAIT;
      WAIT: if (data_ready) state_nx = (lat_load && wb_stall) ? HOLD : IDLE;
      HOLD: if (!wb_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // The pending destination clears in the cycle its writeback is presented.
    if (!wb_ready) begin
      if (accept && aligned && load)           raw_mask[rd]    = 1'b1;
      else if ((state != IDLE) && lat_load)    raw_mask[wb_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_start   <= 1'b0;
      data_write   <= 1'b0;
      data_addr    <= '0;
      data_data_be <= '0;
      data_data_wr <= '0;
      wb_ready     <= 1'b0;
      wb_rd        <= '0;
      wb_value     <= '0;
      fault        <= 1'b0;
      fault_addr   <= '0;
      lat_load     <= 1'b0;
      lat_sign     <= 1'b0;
      lat_size     <= '0;
      lat_lane     <= '0;
    end else begin
      data_start <= accept && aligned;
      fault      <= accept && !aligned;
      wb_ready   <= 1'b0;
      if (accept && !aligned) fault_addr <= addr;
      if (accept && aligned) begin
        data_addr    <= addr[ADDR_W+1:2];
        data_data_be <= be;
        data_data_wr <= wdata;
        data_write   <= !load;
        wb_rd        <= rd;
        lat_load     <= load;
        lat_sign     <= sign_ext;
        lat_size     <= size;
        lat_lane     <= lane;
      end
      if ((state == WAIT) && data_ready && lat_load) begin
        wb_value <= ext;
        wb_ready <= !wb_stall;
      end
      if ((state == HOLD) && !wb_stall) wb_ready <= 1'b1;
    end
  end

endmodule
